// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serializer_pkg
//  Description : Shared constants, load-source encoding and the lane-slice
//                helper for the N-to-1 serializer.
//  Revision    : 1.0  initial release
// ============================================================================
package serializer_pkg;

  localparam int MAX_DATA_WIDTH = 10;
  localparam int MAX_CHANNELS   = 4;
  localparam int CNT_W          = 4;
  localparam int BUS_W          = MAX_DATA_WIDTH * MAX_CHANNELS;

  // Source of the word loaded into the lanes at a load slot
  typedef enum logic [1:0] {
    LOAD_IDLE  = 2'd0,
    LOAD_DATA  = 2'd1,
    LOAD_TRAIN = 2'd2
  } load_sel_e;

  // Extract lane 'lane' (each 'width' bits wide) from a packed multi-lane bus
  function automatic logic [MAX_DATA_WIDTH-1:0] lane_slice(
    input logic [BUS_W-1:0] bus,
    input int               lane,
    input int               width
  );
    logic [BUS_W-1:0] shifted;
    logic [BUS_W-1:0] mask;
    shifted = bus >> (lane * width);
    mask    = {BUS_W{1'b1}} >> (BUS_W - width);
    return MAX_DATA_WIDTH'(shifted & mask);
  endfunction

endpackage : serializer_pkg
`default_nettype wire

// File: rtl/serializer_lane.sv
`default_nettype none
// ============================================================================
//  Module      : serializer_lane
//  Description : One serial lane. On load the first bit goes straight to the
//                registered output and the remaining bits are queued in the
//                shift register, so the first bit appears one cycle after load.
//  Revision    : 1.0  initial release
// ============================================================================
module serializer_lane #(
  parameter int DATA_WIDTH = 5,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  output logic                  dout
);

  logic [DATA_WIDTH-1:0] shreg;

  // Load a new word or shift the next bit out in the selected order
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      dout  <= 1'b0;
    end else if (load) begin
      if (LSB_FIRST) begin
        dout  <= word[0];
        shreg <= word >> 1;
      end else begin
        dout  <= word[DATA_WIDTH-1];
        shreg <= word << 1;
      end
    end else begin
      if (LSB_FIRST) begin
        dout  <= shreg[0];
        shreg <= shreg >> 1;
      end else begin
        dout  <= shreg[DATA_WIDTH-1];
        shreg <= shreg << 1;
      end
    end
  end

endmodule : serializer_lane
`default_nettype wire

// File: rtl/serializer_nto1.sv
`default_nettype none
// ============================================================================
//  Module      : serializer_nto1
//  Description : Multi-lane N-to-1 serializer with a shared bit counter,
//                ready/valid word intake, idle-word underflow fill and a
//                saturating underflow counter.
//                Define SERIALIZER_TRAIN_EN to enable training-word loads
//                requested through the train input.
//  Revision    : 1.0  initial release
// ============================================================================
module serializer_nto1
  import serializer_pkg::*;
#(
  parameter int                    DATA_WIDTH = 5,
  parameter int                    CHANNELS   = 3,
  parameter bit                    LSB_FIRST  = 1'b1,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = '0,
  parameter int unsigned           TRAIN_WORD = 32'd3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           train,
  output logic [CHANNELS-1:0]            dout,
  output logic                           frame_start,
  output logic                           underflow,
  output logic [15:0]                    underflow_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [CNT_W-1:0] cnt;
  logic             load_slot;
  logic             train_load;
  logic             idle_load;
  load_sel_e        load_sel;
  logic [BUS_W-1:0] bus;

  assign load_slot = (cnt == CNT_LAST);
  assign bus       = BUS_W'(in_data);

`ifdef SERIALIZER_TRAIN_EN
  localparam logic [DATA_WIDTH-1:0] TRAIN_VEC = DATA_WIDTH'(TRAIN_WORD);
  assign train_load = load_slot & train;
`else
  // train is ignored in this build; fold it into a sink so it stays connected
  wire unused_train = ^{train, TRAIN_WORD[0]};
  assign train_load = 1'b0;
`endif

  // Ready only at the load slot and never while a training word takes the slot
  assign in_ready  = load_slot & ~train_load & ~rst;
  assign idle_load = load_slot & (load_sel == LOAD_IDLE);

  // Load priority: training, then offered data, otherwise the idle word
  always_comb begin
    load_sel = LOAD_IDLE;
    if (train_load) begin
      load_sel = LOAD_TRAIN;
    end else if (in_valid) begin
      load_sel = LOAD_DATA;
    end
  end

  // Bit counter; reset parks it on the load slot so intake can start at once
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= CNT_LAST;
    end else if (load_slot) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Frame marker, underflow pulse and saturating underflow count
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start   <= 1'b0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      frame_start <= load_slot;
      underflow   <= idle_load;
      if (idle_load && (underflow_cnt != 16'hFFFF)) begin
        underflow_cnt <= underflow_cnt + 16'd1;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] word;

    // Per-lane word selection for the load slot
    always_comb begin
      word = IDLE_WORD;
      case (load_sel)
        LOAD_DATA:  word = DATA_WIDTH'(lane_slice(bus, k, DATA_WIDTH));
`ifdef SERIALIZER_TRAIN_EN
        LOAD_TRAIN: word = TRAIN_VEC;
`endif
        default:    word = IDLE_WORD;
      endcase
    end

    serializer_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .LSB_FIRST  (LSB_FIRST)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (load_slot),
      .word (word),
      .dout (dout[k])
    );
  end : g_lane

endmodule : serializer_nto1
`default_nettype wire

// File: tb/tb_serializer_nto1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serializer_nto1
//  Description : Self-checking bench for serializer_nto1 (default build plus a
//                10-bit MSB-first single-lane instance).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serializer_nto1;

  typedef struct {
    logic        rst;
    logic        valid;
    logic        train;
    logic [14:0] data;
    logic        ready;
    logic [2:0]  dout;
    logic        frame;
    logic        uf;
  } vec_t;

  localparam logic [14:0] WORD_A = {5'b11111, 5'b00001, 5'b10110};
  localparam logic [14:0] WORD_B = {5'b00110, 5'b10000, 5'b01001};
  localparam logic [14:0] JUNK   = 15'h1234;

`ifdef SERIALIZER_TRAIN_EN
  localparam logic TRAIN_ON = 1'b1;
`else
  localparam logic TRAIN_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, train, in_ready, frame_start, underflow;
  logic [14:0] in_data;
  logic [2:0]  dout;
  logic [15:0] underflow_cnt;

  logic        rst2, in_valid2, train2, in_ready2, frame_start2, underflow2;
  logic [9:0]  in_data2;
  logic [0:0]  dout2;
  logic [15:0] underflow_cnt2;

  serializer_nto1 dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .train(train), .dout(dout),
    .frame_start(frame_start), .underflow(underflow),
    .underflow_cnt(underflow_cnt)
  );

  serializer_nto1 #(.DATA_WIDTH(10), .CHANNELS(1), .LSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst(rst2), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .train(train2), .dout(dout2),
    .frame_start(frame_start2), .underflow(underflow2),
    .underflow_cnt(underflow_cnt2)
  );

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  // Lane bits per cycle as {lane2, lane1, lane0}, LSB of each word first
  logic [2:0] a_bits [5];
  logic [2:0] b_bits [5];
  logic [2:0] i_bits [5];
  logic [2:0] t_bits [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle: check in_ready combinationally, then registered outputs
  task automatic run_vec(input vec_t v, input string tag);
    rst = v.rst; in_valid = v.valid; train = v.train; in_data = v.data;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'(v.ready));
    @(posedge clk); #1;
    chk({tag, " dout"},        32'(dout),        32'(v.dout));
    chk({tag, " frame_start"}, 32'(frame_start), 32'(v.frame));
    chk({tag, " underflow"},   32'(underflow),   32'(v.uf));
  endtask

  // One word period: slot row then four shifting rows (in_valid high + junk)
  function automatic void push_word(input logic valid, input logic [14:0] data,
                                    input logic [2:0] b [5], input logic uf);
    tbl.push_back(vec_t'{1'b0, valid, 1'b0, data, 1'b1, b[0], 1'b1, uf});
    for (int i = 1; i < 5; i++)
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, JUNK, 1'b0, b[i], 1'b0, 1'b0});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_cnt;
    logic [9:0]  w2;
    a_bits = '{3'b110, 3'b101, 3'b101, 3'b100, 3'b101};
    b_bits = '{3'b001, 3'b100, 3'b100, 3'b001, 3'b010};
    i_bits = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    t_bits = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b000};

    rst = 1'b1; in_valid = 1'b0; train = 1'b0; in_data = '0;
    rst2 = 1'b1; in_valid2 = 1'b0; train2 = 1'b0; in_data2 = '0;

    // Reset rows, then A, B, an underflow slot, A, and the next A slot
    tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 15'h0,   1'b0, 3'b000, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, WORD_A,  1'b0, 3'b000, 1'b0, 1'b0});
    push_word(1'b1, WORD_A, a_bits, 1'b0);
    push_word(1'b1, WORD_B, b_bits, 1'b0);
    push_word(1'b0, JUNK,   i_bits, 1'b1);
    push_word(1'b1, WORD_A, a_bits, 1'b0);
    tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, WORD_A, 1'b1, a_bits[0], 1'b1, 1'b0});

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++)
      run_vec(tbl[i], $sformatf("row%0d", i));
    chk("underflow_cnt after one idle slot", 32'(underflow_cnt), 32'd1);

    // Mid-word reset at cnt=2: word A is abandoned, B starts cleanly
    run_vec(vec_t'{1'b0, 1'b1, 1'b0, JUNK, 1'b0, a_bits[1], 1'b0, 1'b0}, "pre-rst bit1");
    run_vec(vec_t'{1'b0, 1'b1, 1'b0, JUNK, 1'b0, a_bits[2], 1'b0, 1'b0}, "pre-rst bit2");
    run_vec(vec_t'{1'b1, 1'b1, 1'b0, WORD_A, 1'b0, 3'b000, 1'b0, 1'b0}, "mid-word rst");
    chk("underflow_cnt cleared by rst", 32'(underflow_cnt), 32'd0);
    for (int b = 0; b < 5; b++)
      run_vec(vec_t'{1'b0, 1'b1, 1'b0, (b == 0) ? WORD_B : JUNK, (b == 0),
                     b_bits[b], (b == 0), 1'b0}, $sformatf("post-rst B bit%0d", b));

    // Training for three slots with data held, then the held word
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 5; b++) begin
        logic tr;
        tr = (g < 3);
        run_vec(vec_t'{1'b0, 1'b1, tr, WORD_A,
                       (b == 0) && !(tr && TRAIN_ON),
                       (tr && TRAIN_ON) ? t_bits[b] : a_bits[b],
                       (b == 0), 1'b0}, $sformatf("train g%0d bit%0d", g, b));
      end
    end
    chk("underflow_cnt after training", 32'(underflow_cnt), 32'd0);

    // Saturation: preload the counter near the top, then idle slots
    force dut.underflow_cnt = 16'hFFFC;
    #1;
    release dut.underflow_cnt;
    exp_cnt = 16'hFFFC;
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 5; b++)
        run_vec(vec_t'{1'b0, 1'b0, 1'b0, JUNK, (b == 0), 3'b000, (b == 0), (b == 0)},
                $sformatf("idle g%0d bit%0d", g, b));
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      chk($sformatf("underflow_cnt sat g%0d", g), 32'(underflow_cnt), 32'(exp_cnt));
    end

    // 10-bit MSB-first single lane: 10'h3F0 -> 1111110000, ready every 10
    rst2 = 1'b0; in_valid2 = 1'b1; in_data2 = 10'h3F0;
    w2 = 10'h3F0;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk($sformatf("w10 in_ready k%0d", k), 32'(in_ready2), 32'(k % 10 == 0));
      @(posedge clk); #1;
      chk($sformatf("w10 dout k%0d", k), 32'(dout2), 32'(w2[9 - (k % 10)]));
      chk($sformatf("w10 frame k%0d", k), 32'(frame_start2), 32'(k % 10 == 0));
    end
    chk("w10 underflow_cnt", 32'(underflow_cnt2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serializer_nto1
`default_nettype wire
